// File: rtl/fft_arrange_ctrl.sv
// Output-reorder sequencer for the FFT core: walks the natural index, issues bit-reversed
// result-RAM reads and the matching natural-order writes delayed by the RAM read latency.
module fft_arrange_ctrl #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned RD_LATENCY = 3,
    parameter int unsigned LOG2_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LOG2_W-1:0]     fft_log2,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  ena_arrange,
    output logic [ADDR_WIDTH-1:0] max_point_fft,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr
);

    localparam int unsigned DRAIN_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int unsigned DLY_W   = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state;
    logic [LOG2_W-1:0]     log2_q;
    logic [ADDR_WIDTH-1:0] count;
    logic [DRAIN_W-1:0]    drain_cnt;
    logic [DLY_W-1:0]      dly [RD_LATENCY];

    logic                  size_legal;
    logic [ADDR_WIDTH-1:0] size_mask;
    logic [ADDR_WIDTH-1:0] count_inc;

    // Reverse all ADDR_WIDTH bits, then drop the zero bits that came from above log2.
    function automatic logic [ADDR_WIDTH-1:0] bit_rev(input logic [ADDR_WIDTH-1:0] idx,
                                                      input logic [LOG2_W-1:0]     l2);
        logic [ADDR_WIDTH-1:0] r;
        for (int i = 0; i < int'(ADDR_WIDTH); i++) begin
            r[i] = idx[int'(ADDR_WIDTH) - 1 - i];
        end
        return r >> (ADDR_WIDTH - 32'(l2));
    endfunction

    assign size_legal = (32'(fft_log2) >= 32'd2) && (32'(fft_log2) <= ADDR_WIDTH);
    assign size_mask  = ~({ADDR_WIDTH{1'b1}} << fft_log2);
    assign count_inc  = count + ADDR_WIDTH'(1);

    assign wr_en   = dly[RD_LATENCY-1][ADDR_WIDTH];
    assign wr_addr = dly[RD_LATENCY-1][ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            log2_q        <= '0;
            count         <= '0;
            drain_cnt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
            ena_arrange   <= 1'b0;
            max_point_fft <= '0;
            rd_en         <= 1'b0;
            rd_addr       <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                dly[i] <= '0;
            end
        end else begin
            // Write-side delay line mirrors the read strobe and natural index.
            dly[0] <= {rd_en, count};
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                dly[i] <= dly[i-1];
            end

            cfg_err <= 1'b0;
            done    <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (size_legal) begin
                            state         <= RUN;
                            log2_q        <= fft_log2;
                            max_point_fft <= size_mask;
                            count         <= '0;
                            busy          <= 1'b1;
                            rd_en         <= 1'b1;
                            ena_arrange   <= 1'b1;
                            rd_addr       <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (count == max_point_fft) begin
                        state       <= DRAIN;
                        count       <= '0;
                        drain_cnt   <= '0;
                        rd_en       <= 1'b0;
                        ena_arrange <= 1'b0;
                        rd_addr     <= '0;
                    end else begin
                        count   <= count_inc;
                        rd_addr <= bit_rev(count_inc, log2_q);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_W'(RD_LATENCY - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // Abort overrides everything outside IDLE and flushes in-flight writes.
            if (abort && (state != IDLE)) begin
                state       <= IDLE;
                count       <= '0;
                drain_cnt   <= '0;
                busy        <= 1'b0;
                done        <= 1'b0;
                rd_en       <= 1'b0;
                ena_arrange <= 1'b0;
                rd_addr     <= '0;
                for (int i = 0; i < int'(RD_LATENCY); i++) begin
                    dly[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_arrange_ctrl.sv
// Bench for fft_arrange_ctrl: directed scenarios plus random start/abort/reset traffic,
// checked every cycle against a pass-timeline reference model.
module tb_fft_arrange_ctrl;

    localparam int unsigned AW = 12;
    localparam int unsigned L  = 3;
    localparam int unsigned LW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [LW-1:0] fft_log2;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic          ena_arrange;
    logic [AW-1:0] max_point_fft;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    fft_arrange_ctrl #(.ADDR_WIDTH(AW), .RD_LATENCY(L), .LOG2_W(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .fft_log2      (fft_log2),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err),
        .ena_arrange   (ena_arrange),
        .max_point_fft (max_point_fft),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: one pass described by its start cycle, size and abort point.
    bit            active     = 1'b0;
    int            t0         = 0;
    int            n_pts      = 0;
    int            l2_m       = 0;
    int            abort_at   = 0;
    int            cfg_err_at = -10;
    int            rst_at     = -10;
    int            max_exp    = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit in_pass(input int c);
        return active && (c >= t0 + 1) && (c <= t0 + n_pts + int'(L) + 1) && (c <= abort_at);
    endfunction

    function automatic int ref_rev(input int idx, input int l2);
        int r = 0;
        int v = idx;
        for (int k = 0; k < l2; k++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic check_outputs();
        bit ip;
        bit rd_x;
        bit wr_x;
        bit done_x;
        ip     = in_pass(cyc);
        rd_x   = ip && (cyc <= t0 + n_pts);
        wr_x   = ip && (cyc >= t0 + 1 + int'(L)) && (cyc <= t0 + n_pts + int'(L));
        done_x = ip && (cyc == t0 + n_pts + int'(L) + 1);
        check_eq("busy", 32'(busy), 32'(ip));
        check_eq("rd_en", 32'(rd_en), 32'(rd_x));
        check_eq("ena_arrange", 32'(ena_arrange), 32'(rd_x));
        check_eq("wr_en", 32'(wr_en), 32'(wr_x));
        check_eq("done", 32'(done), 32'(done_x));
        check_eq("cfg_err", 32'(cfg_err), 32'(cyc == cfg_err_at));
        check_eq("max_point_fft", 32'(max_point_fft), 32'(max_exp));
        if (rd_x) check_eq("rd_addr", 32'(rd_addr), 32'(ref_rev(cyc - t0 - 1, l2_m)));
        if (wr_x) check_eq("wr_addr", 32'(wr_addr), 32'(cyc - t0 - 1 - int'(L)));
        if (cyc == rst_at + 1) begin
            check_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
            check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check the registered outputs.
    task automatic step(input logic st, input logic [LW-1:0] l2, input logic ab, input logic rs);
        bit ip;
        start    = st;
        fft_log2 = l2;
        abort    = ab;
        rst      = rs;
        if (rs) begin
            active     = 1'b0;
            max_exp    = 0;
            cfg_err_at = -10;
            rst_at     = cyc;
        end else begin
            ip = in_pass(cyc);
            if (!ip && st) begin
                if (int'(l2) >= 2 && int'(l2) <= int'(AW)) begin
                    active   = 1'b1;
                    t0       = cyc;
                    l2_m     = int'(l2);
                    n_pts    = 1 << l2_m;
                    abort_at = 1 << 30;
                    max_exp  = n_pts - 1;
                end else begin
                    cfg_err_at = cyc + 1;
                end
            end else if (ip && ab) begin
                abort_at = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, LW'(0), 1'b0, 1'b0);
    endtask

    initial begin
        start    = 1'b0;
        abort    = 1'b0;
        rst      = 1'b1;
        fft_log2 = '0;

        for (int i = 0; i < 3; i++) step(1'b0, LW'(0), 1'b0, 1'b1);
        idle(2);

        // Basic N=8 pass.
        step(1'b1, LW'(3), 1'b0, 1'b0);
        idle(14);

        // Full-size pass.
        step(1'b1, LW'(12), 1'b0, 1'b0);
        idle(4110);

        // Start held high: back-to-back N=4 passes.
        for (int i = 0; i < 30; i++) step(1'b1, LW'(2), 1'b0, 1'b0);
        idle(3);

        // Abort at T+5 of an N=16 pass, restart at T+7.
        step(1'b1, LW'(4), 1'b0, 1'b0);
        idle(4);
        step(1'b0, LW'(0), 1'b1, 1'b0);
        idle(1);
        step(1'b1, LW'(4), 1'b0, 1'b0);
        idle(25);

        // Illegal sizes, with abort ignored in IDLE and abort+start in IDLE.
        step(1'b1, LW'(1), 1'b0, 1'b0);
        idle(2);
        step(1'b1, LW'(13), 1'b1, 1'b0);
        idle(2);
        step(1'b1, LW'(2), 1'b1, 1'b0);
        idle(10);

        // Reset mid-drain, then a fresh pass.
        step(1'b1, LW'(3), 1'b0, 1'b0);
        idle(9);
        step(1'b0, LW'(0), 1'b0, 1'b1);
        idle(2);
        step(1'b1, LW'(3), 1'b0, 1'b0);
        idle(15);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic          st;
            logic          ab;
            logic          rs;
            logic [LW-1:0] l2;
            st = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 99) == 0);
            rs = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 9) == 0) l2 = LW'($urandom_range(0, 15));
            else                           l2 = LW'($urandom_range(2, 5));
            step(st, l2, ab, rs);
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_arrange_ctrl.md
Name: fft_arrange_ctrl

Overview:
Sequences the output-reorder pass of the FFT core. On a start request it walks the natural-order output index from 0 to N-1. For each index it issues a bit-reversed read address into the FFT result RAM and a matching natural-order write address, delayed by the RAM read latency. It also drives the enable and terminal-count inputs of the arrange address counter, and reports busy/done to the top-level sequencer.

Parameters:
ADDR_WIDTH, 12, width of all address buses; max FFT size 2^ADDR_WIDTH
RD_LATENCY, 3, result-RAM read latency in cycles (1..8); write side is delayed by this amount
LOG2_W, 4, width of fft_log2 input

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request to begin a reorder pass; sampled only in IDLE
abort  in  1  terminate current pass immediately
fft_log2  in  LOG2_W  log2 of FFT size; legal 2..ADDR_WIDTH; sampled with start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at successful end of pass
cfg_err  out  1  one-cycle pulse when start is rejected for an illegal fft_log2
ena_arrange  out  1  enable for the arrange address counter; high only in RUN
max_point_fft  out  ADDR_WIDTH  N-1 for the latched size; held between passes
rd_en  out  1  result-RAM read strobe
rd_addr  out  ADDR_WIDTH  bit-reversed read address
wr_en  out  1  reorder-RAM write strobe; rd_en delayed RD_LATENCY cycles
wr_addr  out  ADDR_WIDTH  natural-order write address; count delayed RD_LATENCY cycles

Behaviour:
- Reset values (rst=1 at any clock edge, including mid-pass):
  - State IDLE.
  - All outputs 0, including max_point_fft.
  - Count and delay line cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with legal fft_log2: latch log2, set max_point_fft = 2^log2 - 1, clear count, go to RUN.
  - start=1 with illegal fft_log2 (<2 or >ADDR_WIDTH): pulse cfg_err next cycle, stay IDLE, leave max_point_fft unchanged.
- RUN:
  - rd_en=1 and ena_arrange=1.
  - rd_addr[i] = count[log2-1-i] for i<log2; bits at and above log2 are 0.
  - Count increments each cycle.
  - When count==max_point_fft: go to DRAIN and zero count next cycle. Count never exceeds max.
- DRAIN:
  - rd_en=0, ena_arrange=0.
  - Lasts exactly RD_LATENCY cycles, counted by a drain counter, then go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy is still 1 in DONE.
- Delay line: RD_LATENCY-stage shift register of {rd_en, count}. Its output drives {wr_en, wr_addr}; it is registered and shifts every cycle.
- Timing (start sampled at edge T, N = 2^log2):
  - First rd_en/rd_addr=0 in cycle T+1; last read in cycle T+N.
  - wr_en cycles T+1+RD_LATENCY .. T+N+RD_LATENCY, with wr_addr 0..N-1 in order.
  - done in cycle T+N+RD_LATENCY+1; busy cycles T+1 .. T+N+RD_LATENCY+1.
- start while busy is ignored, including in the DONE cycle. The earliest accepted next start is in the first IDLE cycle.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, delay line flushed (wr_en=0), no done pulse.
  - abort in IDLE has no effect.
- abort and start in the same IDLE cycle: start wins, since abort is ignored in IDLE.
- rst has priority over abort and start.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- fft_log2=3, start at T, RD_LATENCY=3 -> rd_addr 0,4,2,6,1,5,3,7 in T+1..T+8; wr_addr 0..7 with wr_en in T+4..T+11; done at T+12; max_point_fft=7; ena_arrange high T+1..T+8 only.
- fft_log2=12 -> 4096 reads; rd_addr sequence is the full 12-bit bit-reversal permutation with no repeats; last rd_addr=4095 at T+4096; done at T+4100.
- Back-to-back: fft_log2=2, second start held high continuously -> second pass accepted only in the first IDLE cycle after done. rd sequence 0,2,1,3 both passes; no wr_en overlap gap errors.
- abort asserted in cycle T+5 of an N=16 pass -> busy=0 and wr_en=0 from T+6; no done; a new start at T+7 runs a clean full pass.
- fft_log2=1 and fft_log2=13 -> cfg_err pulse only; busy stays 0; max_point_fft keeps its prior value.
- rst=1 for one cycle mid-DRAIN -> all outputs 0 next cycle; a subsequent start produces a correct pass from address 0.
